keypad_event_filter: RTL

Sits between the numpad scanner and the calculator control logic. It converts the scanner's level-style 5-bit key code into one debounced, decoded key event per physical press. Each event is held in an output register until the consumer accepts it, so a long press never repeats digit entry or an arithmetic operation. The calculator control consumes `key_valid`/`key_ready` events instead of sampling the raw code every clock.

---
 rtl/keypad_event_filter_pkg.sv | 84 ++++++++
 rtl/keypad_event_filter_if.sv | 43 ++++
 rtl/keypad_event_filter_decode.sv | 31 +++
 rtl/keypad_event_filter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/keypad_event_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared types and constants for the calculator keypad path:
//               filter state enum, operation codes, raw key index constants
//               and the raw-code -> digit/operation decode function used by
//               both the keypad filter and the calculator control.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

  localparam int DIGIT_W      = 4;
  localparam int OP_W         = 3;
  localparam int STABLE_CNT_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } kf_state_e;

  localparam logic [OP_W-1:0] OP_NONE  = 3'd0;
  localparam logic [OP_W-1:0] OP_ENTER = 3'd1;
  localparam logic [OP_W-1:0] OP_ADD   = 3'd2;
  localparam logic [OP_W-1:0] OP_SUB   = 3'd3;
  localparam logic [OP_W-1:0] OP_MUL   = 3'd4;
  localparam logic [OP_W-1:0] OP_DIV   = 3'd5;
  localparam logic [OP_W-1:0] OP_NEG   = 3'd6;

  // Scanner key indices (physical matrix positions, not the printed legend).
  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  typedef struct packed {
    logic               is_digit;
    logic [DIGIT_W-1:0] digit;
    logic [OP_W-1:0]    op;
  } key_evt_t;

  // Digits report op = OP_NONE; operations report digit = 0.
  function automatic key_evt_t decode_key(input logic [3:0] idx);
    key_evt_t e;
    e.is_digit = 1'b1;
    e.digit    = 4'd0;
    e.op       = OP_NONE;
    case (idx)
      KEY_0: e.digit = 4'd1;
      KEY_1: e.digit = 4'd4;
      KEY_2: e.digit = 4'd7;
      KEY_3: e.digit = 4'd0;
      KEY_4: e.digit = 4'd2;
      KEY_5: e.digit = 4'd5;
      KEY_6: e.digit = 4'd8;
      KEY_8: e.digit = 4'd3;
      KEY_9: e.digit = 4'd6;
      KEY_A: e.digit = 4'd9;
      KEY_C: begin e.is_digit = 1'b0; e.op = OP_ENTER; end
      KEY_D: begin e.is_digit = 1'b0; e.op = OP_ADD;   end
      KEY_E: begin e.is_digit = 1'b0; e.op = OP_SUB;   end
      KEY_F: begin e.is_digit = 1'b0; e.op = OP_MUL;   end
      KEY_B: begin e.is_digit = 1'b0; e.op = OP_DIV;   end
      KEY_7: begin e.is_digit = 1'b0; e.op = OP_NEG;   end
      default: begin e.is_digit = 1'b0; e.op = OP_NONE; end
    endcase
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_event_filter_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_event_filter_if
// Description : Key event channel between the keypad filter (master) and
//               the calculator control (slave).
//   key_valid    : event pending (master -> slave)
//   key_ready    : event accepted when high with key_valid (slave -> master)
//   key_is_digit : event is a digit 0-9
//   key_digit    : digit value, 0 for operations
//   key_op       : operation code, OP_NONE for digits
//   dropped      : one-cycle pulse, a new event was discarded
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_event_filter_if;
  import calc_pkg::*;

  logic               key_valid;
  logic               key_ready;
  logic               key_is_digit;
  logic [DIGIT_W-1:0] key_digit;
  logic [OP_W-1:0]    key_op;
  logic               dropped;

  modport master (
    output key_valid,
    output key_is_digit,
    output key_digit,
    output key_op,
    output dropped,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_is_digit,
    input  key_digit,
    input  key_op,
    input  dropped,
    output key_ready
  );

endinterface
`default_nettype wire

// File: rtl/keypad_event_filter_decode.sv
`default_nettype none
// ============================================================================
// Module      : key_decode
// Description : Purely combinational raw key index -> {is_digit, digit, op}.
//               Also usable by the display to echo the last key.
//   code     : in  4  raw key index
//   is_digit : out 1  key is a digit
//   digit    : out 4  digit value (0 for operations)
//   op       : out 3  operation code (OP_NONE for digits)
// Revision    : 1.0 - initial release
// ============================================================================
module key_decode
  import calc_pkg::*;
(
  input  logic [3:0]         code,
  output logic               is_digit,
  output logic [DIGIT_W-1:0] digit,
  output logic [OP_W-1:0]    op
);

  key_evt_t dec;

  always_comb begin
    dec      = decode_key(code);
    is_digit = dec.is_digit;
    digit    = dec.digit;
    op       = dec.op;
  end

endmodule
`default_nettype wire

// File: rtl/keypad_event_filter.sv
`default_nettype none
// ============================================================================
// Module      : keypad_event_filter
// Description : Debounces the scanner's level-style key code and produces one
//               decoded key event per physical press, held in an output
//               register until the consumer accepts it.
//   DEBOUNCE_CYCLES : identical samples needed to accept press / release
//   clock           : in  1  system clock, rising edge
//   reset           : in  1  asynchronous, active-low
//   value           : in  5  raw code, [4] key present, [3:0] key index
//   evt             : master side of keypad_event_filter_if
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_event_filter
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
)
(
  input  logic                         clock,
  input  logic                         reset,
  input  logic [4:0]                   value,
  keypad_event_filter_if.master        evt
);

  localparam logic [STABLE_CNT_W-1:0] DB_LIMIT = STABLE_CNT_W'(DEBOUNCE_CYCLES);

  kf_state_e                state_q, state_d;
  logic [3:0]               cand_q, cand_d;
  logic [STABLE_CNT_W-1:0]  stable_cnt_q, stable_cnt_d;
  logic                     key_valid_q, key_valid_d;
  logic                     key_is_digit_q, key_is_digit_d;
  logic [DIGIT_W-1:0]       key_digit_q, key_digit_d;
  logic [OP_W-1:0]          key_op_q, key_op_d;
  logic                     dropped_q, dropped_d;

  logic                     key_down;
  logic                     emit;
  logic                     accept;
  logic [STABLE_CNT_W-1:0]  cnt_inc;
  logic                     dec_is_digit;
  logic [DIGIT_W-1:0]       dec_digit;
  logic [OP_W-1:0]          dec_op;

  assign key_down = value[4];
  assign accept   = key_valid_q & evt.key_ready;
  // Saturating increment: the counter never wraps back to a small value.
  assign cnt_inc  = (stable_cnt_q == '1) ? stable_cnt_q : stable_cnt_q + 1'b1;

  // The candidate equals the live code whenever an emit fires.
  key_decode u_key_decode (
    .code     (cand_q),
    .is_digit (dec_is_digit),
    .digit    (dec_digit),
    .op       (dec_op)
  );

  // Debounce FSM and stable-sample counter.
  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    stable_cnt_d = stable_cnt_q;
    emit         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_down) begin
          cand_d       = value[3:0];
          stable_cnt_d = STABLE_CNT_W'(1);
          state_d      = ST_PRESS_DB;
        end
      end
      ST_PRESS_DB: begin
        if (!key_down) begin
          state_d = ST_IDLE;
        end else if (value[3:0] != cand_q) begin
          // Bounce onto a different key: restart on the new code.
          cand_d       = value[3:0];
          stable_cnt_d = STABLE_CNT_W'(1);
        end else begin
          stable_cnt_d = cnt_inc;
          if (cnt_inc == DB_LIMIT) begin
            emit    = 1'b1;
            state_d = ST_HELD;
          end
        end
      end
      ST_HELD: begin
        // Code changes while held are deliberately ignored.
        if (!key_down) begin
          stable_cnt_d = STABLE_CNT_W'(1);
          state_d      = ST_RELEASE_DB;
        end
      end
      ST_RELEASE_DB: begin
        if (key_down) begin
          state_d = ST_HELD;
        end else begin
          stable_cnt_d = cnt_inc;
          if (cnt_inc == DB_LIMIT) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output event register. An emit may reload it on the same edge it is
  // accepted; otherwise a pending event wins and the new one is dropped.
  always_comb begin
    key_valid_d    = key_valid_q;
    key_is_digit_d = key_is_digit_q;
    key_digit_d    = key_digit_q;
    key_op_d       = key_op_q;
    dropped_d      = 1'b0;
    if (accept) begin
      key_valid_d    = 1'b0;
      key_is_digit_d = 1'b0;
      key_digit_d    = '0;
      key_op_d       = OP_NONE;
    end
    if (emit) begin
      if (!key_valid_q || accept) begin
        key_valid_d    = 1'b1;
        key_is_digit_d = dec_is_digit;
        key_digit_d    = dec_digit;
        key_op_d       = dec_op;
      end else begin
        dropped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      cand_q         <= 4'd0;
      stable_cnt_q   <= '0;
      key_valid_q    <= 1'b0;
      key_is_digit_q <= 1'b0;
      key_digit_q    <= '0;
      key_op_q       <= OP_NONE;
      dropped_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cand_q         <= cand_d;
      stable_cnt_q   <= stable_cnt_d;
      key_valid_q    <= key_valid_d;
      key_is_digit_q <= key_is_digit_d;
      key_digit_q    <= key_digit_d;
      key_op_q       <= key_op_d;
      dropped_q      <= dropped_d;
    end
  end

  assign evt.key_valid    = key_valid_q;
  assign evt.key_is_digit = key_is_digit_q;
  assign evt.key_digit    = key_digit_q;
  assign evt.key_op       = key_op_q;
  assign evt.dropped      = dropped_q;

endmodule
`default_nettype wire
